controlador_secded: RTL and testbench
=====================================

// Module: controlador_secded
// PURPOSE
//  Sequences one Hamming(8,4) SECDED decode per transaction around an external combinational decoder.
//  - Accepts a codeword and a 4-bit forced-data word over a valid/ready handshake.
//  - Drives both onto the decoder, waits a settle window, then samples syndrome, parity and received word.
//  - Corrects single errors, flags double errors, keeps saturating error counters.
//  - Returns the result over a valid/ready handshake.
// PARAMETERS
//  SETTLE_CYC  1  cycles the decoder inputs are held before sampling (1..15)
//  CNT_W       8  width of each saturating error counter
// PORTS
//  reloj         in   1      clock; all state updates on rising edge
//  reset         in   1      synchronous, active-high reset
//  in_valid      in   1      request carries a valid codeword
//  in_ready      out  1      controller can accept a request
//  in_palabra    in   8      Hamming codeword, bits[7:0] = positions 1..8
//  in_p_error    in   4      forced data bits {pos7,pos6,pos5,pos3}
//  dec_palabra   out  8      codeword driven to the decoder
//  dec_p_error   out  4      forced data driven to the decoder
//  dec_recibido  in   8      decoder's received word
//  dec_s1/s2/s3  in   1 each decoder syndrome bits
//  dec_st        in   1      decoder overall parity
//  out_valid     out  1      result valid
//  out_ready     in   1      consumer accepts the result
//  corregido     out  8      corrected codeword (raw word if double error)
//  data_out      out  4      {corregido[6],[5],[4],[2]}
//  err_pos       out  4      corrected position 1..8; 0 means none
//  err_simple    out  1      single error corrected, including overall-parity-only
//  err_doble     out  1      uncorrectable double error
//  cnt_simple    out  CNT_W  saturating count of single errors
//  cnt_doble     out  CNT_W  saturating count of double errors
//  clr_cnt       in   1      synchronous clear of both counters
//  busy          out  1      FSM is not IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE. in_ready=1; every other output and every counter is 0.
//  FSM states:
//  - IDLE: in_ready=1. On in_valid&in_ready, latch inputs onto dec_*, load settle counter, go to DRIVE.
//  - DRIVE: dec_* held stable. Counter decrements; at 0, go to SAMPLE.
//  - SAMPLE: one cycle. Register results with syn={s3,s2,s1}:
//    - syn=0, st=0: no error. corregido=recibido, err_pos=0.
//    - syn!=0, st=1: flip recibido[syn-1]. err_pos=syn, err_simple=1.
//    - syn=0, st=1: flip recibido[7]. err_pos=8, err_simple=1.
//    - syn!=0, st=0: corregido=recibido, err_pos=0, err_doble=1.
//    Then go to DONE.
//  - DONE: out_valid=1 with outputs stable. On out_ready, go to IDLE and drop out_valid the next cycle.
//  - Request-to-out_valid latency = SETTLE_CYC+2 cycles.
//  Handshake rules:
//  - No new request is accepted until the result is consumed; in_ready=0 outside IDLE.
//  - The result stays valid until out_ready; there is no back-to-back overlap.
//  Counters:
//  - Increment in SAMPLE on err_simple or err_doble, and hold at 2^CNT_W-1.
//  - clr_cnt has priority over a same-cycle increment.
//  Reset in any state aborts the transaction: no out_valid and no counter update.
// TESTING
//  1. palabra=8'h55, p_error=4'b1011 -> data_out=1011, err_pos=0, both flags 0.
//  2. palabra=8'h55, p_error=4'b1010 -> syn=3, corregido=8'h55, data_out=1011, err_simple=1, cnt_simple+1.
//  3. palabra=8'h55, p_error=4'b1000 -> syn=6, st=0, err_doble=1, data_out=1000, cnt_doble+1.
//  4. palabra=8'hD5, p_error=4'b1011 -> syn=0, st=1, err_pos=8, corregido=8'h55.
//  5. Hold out_ready=0 for 5 cycles -> out_valid and outputs stable, in_ready=0; reset in DRIVE -> IDLE, counters 0.
//  6. CNT_W=2: 5 single errors -> cnt_simple=3; clr_cnt with a 6th single error -> 0.

Source files
------------

// File: rtl/controlador_secded_if.sv
// Request/response bundle between a client and the SECDED decode controller.
interface controlador_secded_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_palabra;
    logic [3:0] in_p_error;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] corregido;
    logic [3:0] data_out;
    logic [3:0] err_pos;
    logic       err_simple;
    logic       err_doble;

    modport master (
        output in_valid, in_palabra, in_p_error, out_ready,
        input  in_ready, out_valid, corregido, data_out, err_pos, err_simple, err_doble
    );

    modport slave (
        input  in_valid, in_palabra, in_p_error, out_ready,
        output in_ready, out_valid, corregido, data_out, err_pos, err_simple, err_doble
    );
endinterface

// File: rtl/controlador_secded.sv
// Sequences one Hamming(8,4) SECDED decode per request around an external combinational
// decoder, correcting single errors, flagging double errors and counting both.
module controlador_secded #(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             reloj,
    input  logic             reset,
    controlador_secded_if.slave bus,
    output logic [7:0]       dec_palabra,
    output logic [3:0]       dec_p_error,
    input  logic [7:0]       dec_recibido,
    input  logic             dec_s1,
    input  logic             dec_s2,
    input  logic             dec_s3,
    input  logic             dec_st,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_simple,
    output logic [CNT_W-1:0] cnt_doble,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} estado_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    estado_t    estado, estado_sig;
    logic [3:0] settle_cnt;
    logic [7:0] corregido_q;
    logic [3:0] err_pos_q;
    logic       err_simple_q;
    logic       err_doble_q;

    logic [2:0] syn;
    logic [2:0] flip_idx;
    logic [7:0] fix_word;
    logic [3:0] fix_pos;
    logic       fix_simple;
    logic       fix_doble;

    always_ff @(posedge reloj) begin
        if (reset) estado <= IDLE;
        else       estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:   if (bus.in_valid) estado_sig = DRIVE;
            DRIVE:  if (settle_cnt == 4'd0) estado_sig = SAMPLE;
            SAMPLE: estado_sig = DONE;
            DONE:   if (bus.out_ready) estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = (estado == IDLE);
        bus.out_valid  = (estado == DONE);
        busy           = (estado != IDLE);
        bus.corregido  = corregido_q;
        bus.data_out   = {corregido_q[6], corregido_q[5], corregido_q[4], corregido_q[2]};
        bus.err_pos    = err_pos_q;
        bus.err_simple = err_simple_q;
        bus.err_doble  = err_doble_q;
    end

    // Syndrome 0 with bad overall parity wraps syn-1 to 7, i.e. the parity bit at position 8.
    always_comb begin
        syn        = {dec_s3, dec_s2, dec_s1};
        flip_idx   = syn - 3'd1;
        fix_word   = dec_recibido;
        fix_pos    = 4'd0;
        fix_simple = 1'b0;
        fix_doble  = 1'b0;
        if (dec_st) begin
            fix_word   = dec_recibido ^ (8'd1 << flip_idx);
            fix_pos    = (syn == 3'd0) ? 4'd8 : {1'b0, syn};
            fix_simple = 1'b1;
        end else if (syn != 3'd0) begin
            fix_doble = 1'b1;
        end
    end

    always_ff @(posedge reloj) begin
        if (reset) begin
            settle_cnt   <= 4'd0;
            dec_palabra  <= 8'd0;
            dec_p_error  <= 4'd0;
            corregido_q  <= 8'd0;
            err_pos_q    <= 4'd0;
            err_simple_q <= 1'b0;
            err_doble_q  <= 1'b0;
        end else begin
            case (estado)
                IDLE: if (bus.in_valid) begin
                    dec_palabra <= bus.in_palabra;
                    dec_p_error <= bus.in_p_error;
                    settle_cnt  <= 4'(SETTLE_CYC);
                end
                DRIVE: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                SAMPLE: begin
                    corregido_q  <= fix_word;
                    err_pos_q    <= fix_pos;
                    err_simple_q <= fix_simple;
                    err_doble_q  <= fix_doble;
                end
                default: ;
            endcase
        end
    end

    // A clear wins over an increment landing in the same cycle.
    always_ff @(posedge reloj) begin
        if (reset || clr_cnt) begin
            cnt_simple <= '0;
            cnt_doble  <= '0;
        end else if (estado == SAMPLE) begin
            if (fix_simple && cnt_simple != CNT_MAX) cnt_simple <= cnt_simple + 1'b1;
            if (fix_doble && cnt_doble != CNT_MAX)   cnt_doble  <= cnt_doble + 1'b1;
        end
    end

endmodule

// File: tb/tb_controlador_secded.sv
// Directed bench for controlador_secded with a behavioural Hamming(8,4) decoder alongside it.
module tb_controlador_secded;

    localparam int SETTLE = 3;
    localparam int CW     = 2;

    logic          reloj = 1'b0;
    logic          reset;
    logic [7:0]    dec_palabra;
    logic [3:0]    dec_p_error;
    logic [7:0]    dec_recibido;
    logic          dec_s1, dec_s2, dec_s3, dec_st;
    logic          clr_cnt;
    logic [CW-1:0] cnt_simple, cnt_doble;
    logic          busy;
    int            total = 0;
    int            bad   = 0;
    int            lat;

    always #5 reloj = ~reloj;

    controlador_secded_if bus ();

    controlador_secded #(.SETTLE_CYC(SETTLE), .CNT_W(CW)) dut (
        .reloj        (reloj),
        .reset        (reset),
        .bus          (bus.slave),
        .dec_palabra  (dec_palabra),
        .dec_p_error  (dec_p_error),
        .dec_recibido (dec_recibido),
        .dec_s1       (dec_s1),
        .dec_s2       (dec_s2),
        .dec_s3       (dec_s3),
        .dec_st       (dec_st),
        .clr_cnt      (clr_cnt),
        .cnt_simple   (cnt_simple),
        .cnt_doble    (cnt_doble),
        .busy         (busy)
    );

    // Forced data replaces positions 7,6,5,3 (bits 6,5,4,2) of the driven codeword.
    assign dec_recibido = {dec_palabra[7], dec_p_error[3], dec_p_error[2], dec_p_error[1],
                           dec_palabra[3], dec_p_error[0], dec_palabra[1:0]};
    assign dec_s1 = ^{dec_recibido[0], dec_recibido[2], dec_recibido[4], dec_recibido[6]};
    assign dec_s2 = ^{dec_recibido[1], dec_recibido[2], dec_recibido[5], dec_recibido[6]};
    assign dec_s3 = ^{dec_recibido[3], dec_recibido[4], dec_recibido[5], dec_recibido[6]};
    assign dec_st = ^dec_recibido;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] wanted);
        total++;
        if (observed !== wanted) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, wanted);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] palabra, input logic [3:0] p_error);
        @(negedge reloj);
        bus.in_valid   = 1'b1;
        bus.in_palabra = palabra;
        bus.in_p_error = p_error;
        checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge reloj);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge reloj);
            #1;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(SETTLE + 2));
        checkOutput("in_ready_done", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic consume();
        @(negedge reloj);
        bus.out_ready = 1'b1;
        @(posedge reloj);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("valid_drop", 32'(bus.out_valid), 32'd0);
        checkOutput("in_ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen_valid;
        reset          = 1'b1;
        clr_cnt        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_palabra = 8'h00;
        bus.in_p_error = 4'h0;
        bus.out_ready  = 1'b0;
        repeat (3) @(posedge reloj);
        @(negedge reloj);
        reset = 1'b0;

        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_corregido", 32'(bus.corregido), 32'h0);
        checkOutput("rst_err_pos", 32'(bus.err_pos), 32'h0);
        checkOutput("rst_flags", 32'({bus.err_simple, bus.err_doble}), 32'h0);
        checkOutput("rst_counts", 32'({cnt_simple, cnt_doble}), 32'h0);
        checkOutput("rst_dec_palabra", 32'(dec_palabra), 32'h0);

        // Clean codeword
        applyStimulus(8'h55, 4'b1011);
        checkOutput("t1_corregido", 32'(bus.corregido), 32'h55);
        checkOutput("t1_data_out", 32'(bus.data_out), 32'hB);
        checkOutput("t1_err_pos", 32'(bus.err_pos), 32'd0);
        checkOutput("t1_flags", 32'({bus.err_simple, bus.err_doble}), 32'h0);
        consume();

        // Single error at position 3
        applyStimulus(8'h55, 4'b1010);
        checkOutput("t2_corregido", 32'(bus.corregido), 32'h55);
        checkOutput("t2_data_out", 32'(bus.data_out), 32'hB);
        checkOutput("t2_err_pos", 32'(bus.err_pos), 32'd3);
        checkOutput("t2_flags", 32'({bus.err_simple, bus.err_doble}), 32'b10);
        checkOutput("t2_cnt_simple", 32'(cnt_simple), 32'd1);
        consume();

        // Double error, syndrome 6
        applyStimulus(8'h55, 4'b1000);
        checkOutput("t3_corregido", 32'(bus.corregido), 32'h41);
        checkOutput("t3_data_out", 32'(bus.data_out), 32'h8);
        checkOutput("t3_err_pos", 32'(bus.err_pos), 32'd0);
        checkOutput("t3_flags", 32'({bus.err_simple, bus.err_doble}), 32'b01);
        checkOutput("t3_cnt_doble", 32'(cnt_doble), 32'd1);
        consume();

        // Overall parity bit only
        applyStimulus(8'hD5, 4'b1011);
        checkOutput("t4_corregido", 32'(bus.corregido), 32'h55);
        checkOutput("t4_err_pos", 32'(bus.err_pos), 32'd8);
        checkOutput("t4_flags", 32'({bus.err_simple, bus.err_doble}), 32'b10);
        checkOutput("t4_cnt_simple", 32'(cnt_simple), 32'd2);
        checkOutput("t4_cnt_doble", 32'(cnt_doble), 32'd1);
        consume();

        // Back-pressure: result must hold and a new request must be refused
        applyStimulus(8'h55, 4'b1010);
        checkOutput("t5_cnt_simple", 32'(cnt_simple), 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge reloj);
            bus.in_valid   = 1'b1;
            bus.in_palabra = 8'hAA;
            bus.in_p_error = 4'h0;
            checkOutput("t5_hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("t5_hold_corregido", 32'(bus.corregido), 32'h55);
            checkOutput("t5_hold_err_pos", 32'(bus.err_pos), 32'd3);
            checkOutput("t5_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        checkOutput("t5_dec_unchanged", 32'(dec_palabra), 32'h55);
        consume();

        // Reset while in DRIVE aborts the transaction
        @(negedge reloj);
        bus.in_valid   = 1'b1;
        bus.in_palabra = 8'h55;
        bus.in_p_error = 4'b1000;
        @(posedge reloj);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("t5_busy_drive", 32'(busy), 32'd1);
        @(negedge reloj);
        reset = 1'b1;
        @(negedge reloj);
        reset = 1'b0;
        checkOutput("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("t5_rst_busy", 32'(busy), 32'd0);
        checkOutput("t5_rst_counts", 32'({cnt_simple, cnt_doble}), 32'h0);
        checkOutput("t5_rst_corregido", 32'(bus.corregido), 32'h0);
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge reloj);
            seen_valid = seen_valid | bus.out_valid;
        end
        checkOutput("t5_no_valid_after_abort", 32'(seen_valid), 32'd0);
        checkOutput("t5_no_count_after_abort", 32'(cnt_doble), 32'd0);

        // Counter saturation at 2^CW-1
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) applyStimulus(8'h55, 4'b1010);
            else            applyStimulus(8'hD5, 4'b1011);
            checkOutput("t6_err_simple", 32'(bus.err_simple), 32'd1);
            checkOutput("t6_cnt_simple", 32'(cnt_simple), (i < 3) ? 32'(i + 1) : 32'd3);
            consume();
        end

        // Clear held across a single error, including the SAMPLE cycle
        clr_cnt = 1'b1;
        applyStimulus(8'h55, 4'b1010);
        checkOutput("t6_clr_err_simple", 32'(bus.err_simple), 32'd1);
        checkOutput("t6_clr_cnt_simple", 32'(cnt_simple), 32'd0);
        consume();
        clr_cnt = 1'b0;

        applyStimulus(8'h55, 4'b1000);
        checkOutput("t6_post_cnt_doble", 32'(cnt_doble), 32'd1);
        checkOutput("t6_post_cnt_simple", 32'(cnt_simple), 32'd0);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
